// File: rtl/pixel_frame_serializer.sv
// Frame-to-row serializer: a shadow register takes the next frame while the working
// buffer streams the current one row per beat, so frames follow each other without gaps.
module pixel_frame_serializer #(
  parameter int WIDTH  = 224,
  parameter int HEIGHT = 96,
  parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int FCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*HEIGHT-1:0]   pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [WIDTH-1:0]          row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [ROW_W-1:0]          row_idx,
  output logic                      sof,
  output logic                      eof,
  output logic [FCNT_W-1:0]         frame_cnt
);

  localparam int FRAME_W = WIDTH * HEIGHT;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic [FRAME_W-1:0] shadow_reg;
  logic [FRAME_W-1:0] work_reg;
  logic               shadow_full_reg;
  logic               active_reg;
  logic [ROW_W-1:0]   row_idx_reg;
  logic [FCNT_W-1:0]  frame_cnt_reg;

  logic accept;
  logic beat;
  logic last_row;
  logic load;

  // Working buffer viewed as an array of rows for the output mux.
  logic [WIDTH-1:0] rows [HEIGHT];

  generate
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_rows
      assign rows[gi] = work_reg[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign accept   = pix_valid & ~shadow_full_reg;
  assign beat     = active_reg & row_ready;
  assign last_row = (row_idx_reg == LAST_ROW);
  // Accept needs an empty shadow and load needs a full one, so they never coincide.
  assign load     = shadow_full_reg & (~active_reg | (beat & last_row));

  always_comb begin
    row_data = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      if (row_idx_reg == ROW_W'(i)) begin
        row_data = rows[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
    end else if (accept) begin
      shadow_reg      <= pix_in;
      shadow_full_reg <= 1'b1;
    end else if (load) begin
      shadow_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg    <= '0;
      active_reg  <= 1'b0;
      row_idx_reg <= '0;
    end else if (load) begin
      work_reg    <= shadow_reg;
      active_reg  <= 1'b1;
      row_idx_reg <= '0;
    end else if (beat) begin
      if (last_row) begin
        active_reg  <= 1'b0;
        row_idx_reg <= '0;
      end else begin
        row_idx_reg <= row_idx_reg + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (beat && last_row) begin
      frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
    end
  end

  assign pix_ready = ~shadow_full_reg;
  assign row_valid = active_reg;
  assign row_idx   = row_idx_reg;
  assign sof       = active_reg & (row_idx_reg == '0);
  assign eof       = active_reg & last_row;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_pixel_frame_serializer.sv
// Bench for pixel_frame_serializer: directed scenarios then random traffic, all checked
// every cycle against a frame-queue reference model; a second instance has a 2-bit counter.
module tb_pixel_frame_serializer;
  localparam int W = 4;
  localparam int H = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W*H-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          row_ready = 1'b0;

  logic          pix_ready;
  logic [W-1:0]  row_data;
  logic          row_valid;
  logic [1:0]    row_idx;
  logic          sof;
  logic          eof;
  logic [15:0]   frame_cnt;

  logic          w_pix_ready;
  logic [W-1:0]  w_row_data;
  logic          w_row_valid;
  logic [1:0]    w_row_idx;
  logic          w_sof;
  logic          w_eof;
  logic [1:0]    w_frame_cnt;

  pixel_frame_serializer #(.WIDTH(W), .HEIGHT(H), .FCNT_W(16)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .sof(sof), .eof(eof), .frame_cnt(frame_cnt)
  );

  pixel_frame_serializer #(.WIDTH(W), .HEIGHT(H), .FCNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(w_pix_ready),
    .row_data(w_row_data), .row_valid(w_row_valid), .row_ready(row_ready), .row_idx(w_row_idx),
    .sof(w_sof), .eof(w_eof), .frame_cnt(w_frame_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: frames waiting to be sent, the frame on the wire and its row.
  logic [W*H-1:0] pend_q[$];
  logic [W*H-1:0] cur_frame = '0;
  bit             cur_valid = 0;
  int             m_row = 0;
  int             m_cnt = 0;
  bit             last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    cur_valid = 0;
    m_row = 0;
    m_cnt = 0;
    last_acc = 0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] exp_row;
    exp_row = cur_frame[m_row*W +: W];
    chk("pix_ready", 32'(pix_ready), 32'(pend_q.size() == 0));
    chk("row_valid", 32'(row_valid), 32'(cur_valid));
    chk("row_idx", 32'(row_idx), 32'(m_row));
    chk("sof", 32'(sof), 32'(cur_valid && m_row == 0));
    chk("eof", 32'(eof), 32'(cur_valid && m_row == H - 1));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt % 65536));
    chk("wrap_frame_cnt", 32'(w_frame_cnt), 32'(m_cnt % 4));
    chk("wrap_row_valid", 32'(w_row_valid), 32'(cur_valid));
    chk("wrap_pix_ready", 32'(w_pix_ready), 32'(pend_q.size() == 0));
    chk("wrap_flags", 32'({w_sof, w_eof, w_row_idx}), 32'({sof, eof, row_idx}));
    if (cur_valid) begin
      chk("row_data", 32'(row_data), 32'(exp_row));
      chk("wrap_row_data", 32'(w_row_data), 32'(exp_row));
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check 1ns later.
  task automatic step();
    bit acc;
    bit beat;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc  = pix_valid && (pend_q.size() == 0);
      beat = cur_valid && row_ready;
      if (beat) begin
        $display("[TB] beat frame=%h row=%0d data=%h", cur_frame, m_row, cur_frame[m_row*W +: W]);
        if (m_row == H - 1) begin
          m_cnt++;
          cur_valid = 0;
          m_row = 0;
        end else begin
          m_row++;
        end
      end
      if (!cur_valid && pend_q.size() != 0) begin
        cur_frame = pend_q.pop_front();
        cur_valid = 1;
        m_row = 0;
      end
      if (acc) pend_q.push_back(pix_in);
      last_acc = acc;
    end
    #1 check_outputs();
  endtask

  task automatic offer(input logic [W*H-1:0] f, input int max_cycles);
    pix_in = f;
    pix_valid = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (last_acc) break;
    end
    pix_valid = 1'b0;
    pix_in = 12'($urandom);
  endtask

  initial begin
    model_reset();
    #1 check_outputs();
    step();
    step();
    rst = 1'b0;

    // Single frame, then idle
    row_ready = 1'b1;
    offer(12'hABC, 4);
    repeat (5) step();

    // Stall on row 1 for five cycles
    offer(12'hABC, 4);
    step();
    step();
    row_ready = 1'b0;
    repeat (5) step();
    row_ready = 1'b1;
    repeat (4) step();

    // Back-to-back frames with no gap
    offer(12'h123, 10);
    offer(12'h456, 10);
    repeat (8) step();

    // Backpressure: third frame held upstream until the sink drains
    row_ready = 1'b0;
    offer(12'h7A1, 10);
    offer(12'h8B2, 10);
    pix_in = 12'h9C3;
    pix_valid = 1'b1;
    repeat (5) step();
    row_ready = 1'b1;
    offer(12'h9C3, 20);
    repeat (12) step();

    // Asynchronous reset mid-frame
    offer(12'hDEF, 4);
    step();
    step();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    step();
    rst = 1'b0;
    offer(12'h5E7, 4);
    repeat (6) step();

    // Random traffic; many frames exercise the 2-bit counter wrap
    for (int n = 0; n < 600; n++) begin
      pix_in    = 12'($urandom);
      pix_valid = ($urandom_range(0, 3) != 0);
      row_ready = ($urandom_range(0, 4) != 0);
      step();
    end
    pix_valid = 1'b0;
    row_ready = 1'b1;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_frame_serializer.md
Name: pixel_frame_serializer

Overview:
- Downstream stage of the visual-crypto display top. It consumes each flat WIDTH*HEIGHT pixel frame produced by the segment-to-pixel stage and streams it out one row per beat to the display/transport interface.
- Contains a one-frame input shadow register plus a working buffer, so a new frame can be accepted while the current one is being sent. This gives zero-bubble frame-to-frame streaming.

Parameters:
- WIDTH, 224, pixels per row; row_data width.
- HEIGHT, 96, rows per frame.
- ROW_W, max(1,clog2(HEIGHT)), width of row_idx.
- FCNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  WIDTH*HEIGHT  pixel frame; pixel (x,y) is at bit y*WIDTH+x.
- pix_valid  in  1  pix_in holds a frame.
- pix_ready  out  1  shadow register empty; a frame is accepted when pix_valid & pix_ready.
- row_data  out  WIDTH  current row; bit x is pixel (x,row_idx).
- row_valid  out  1  row_data is valid.
- row_ready  in  1  sink accepts the row; a beat completes when row_valid & row_ready.
- row_idx  out  ROW_W  index of the current row, 0..HEIGHT-1.
- sof  out  1  row_valid & (row_idx==0).
- eof  out  1  row_valid & (row_idx==HEIGHT-1).
- frame_cnt  out  FCNT_W  count of fully transmitted frames.

Behaviour:
- Reset (asynchronous, immediate): shadow_full=0 (pix_ready=1), active=0 (row_valid=0), row_idx=0, frame_cnt=0, buffers=0. Reset mid-frame discards both the working and shadow frames. No partial frame resumes after reset.
- State: shadow_full and active flags; two regs of WIDTH*HEIGHT bits (shadow, work); row counter.
- Accept: pix_ready = !shadow_full, registered and not combinationally dependent on row_ready.
  - On a handshake edge: shadow <= pix_in, shadow_full <= 1.
  - pix_in is don't-care when not accepted.
- Load: at any edge where shadow_full is set and either (active==0) or (last-row beat completes):
  - work <= shadow, shadow_full <= 0, active <= 1, row_idx <= 0.
- Latency: frame accepted at edge T → row 0 valid after edge T+1.
- Back-to-back: if shadow is full when the last row (HEIGHT-1) completes, row 0 of the next frame is presented in the next cycle with no idle cycle, and row_valid stays high.
- Accept and load on the same edge cannot occur. pix_ready is low while shadow_full; it rises the cycle after a load.
- Send: row_valid = active, row_data = work[row_idx*WIDTH +: WIDTH].
  - On a beat with row_idx<HEIGHT-1: row_idx++.
  - On a beat with row_idx==HEIGHT-1: frame_cnt++ (wraps modulo 2^FCNT_W); then load if shadow_full, else active<=0 and row_idx<=0.
- Stall: while row_valid & !row_ready, row_data, row_idx, sof and eof are held stable.
- row_valid never drops without a completed beat, except on reset.
- HEIGHT==1: sof and eof are asserted together on every beat; each beat ends a frame.
- row_ready asserted while row_valid=0 has no effect.
- Frames are never dropped or reordered; backpressure propagates upstream through pix_ready.

Test Plan (WIDTH=4, HEIGHT=3 unless stated):
- Single frame: pix_in=12'hABC, pulse pix_valid one cycle, row_ready=1 → row_valid rises after the edge following accept. Rows 4'hC (sof), 4'hB, 4'hA (eof) on consecutive cycles. frame_cnt 0→1, then row_valid=0.
- Stall: same frame, row_ready=0 for 5 cycles during row 1 → row_data=4'hB and row_idx=1 held stable. Resumes to 4'hA on release; total frame_cnt=1.
- Back-to-back: offer 12'h123 then 12'h456 continuously with row_ready=1 → rows 3,2,1,6,5,4 with no gap between frames. pix_ready low while shadow full; frame_cnt=2.
- Backpressure: row_ready=0, offer three frames → the first two are accepted, then pix_ready stays 0 and the third is held. Releasing row_ready delivers all three in order.
- Reset mid-frame: assert rst during row 1 → all outputs reset immediately. After release, the next accepted frame streams from row 0; frame_cnt restarts at 0.
- Wrap: FCNT_W=2, stream 5 frames → frame_cnt sequence 1,2,3,0,1.
